// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller and its output FIFO.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ARMED    = 2'd1,
      RECV     = 2'd2,
      STORE    = 2'd3
   } rx_ctrl_state_t;

   typedef struct packed {
      logic [2:0] error;
      logic [7:0] data;
   } rx_entry_t;

   localparam int ERR_PAR  = 2;
   localparam int ERR_STRT = 1;
   localparam int ERR_STP  = 0;

   function automatic logic any_error(input logic [2:0] err);
      return err[ERR_PAR] | err[ERR_STRT] | err[ERR_STP];
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO of received entries; a push on a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module rx_ctrl_fifo
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  rx_entry_t              push_data,
   input  logic                   pop,
   output rx_entry_t              head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   rx_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: the head is masked by the caller while empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: latches line config, gates the receive unit, tracks
// frames with a watchdog and buffers completed bytes for a valid/ready consumer.
//
// state    | meaning
// DISABLED | receiver off, config may be latched
// ARMED    | receiver on, waiting for a frame to start
// RECV     | frame in progress, watchdog running
// STORE    | one cycle: push finished frame into the FIFO
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        cfg_enable,
   input  logic [1:0]                  cfg_baud,
   input  logic [1:0]                  cfg_parity,
   input  logic                        clr_status,
   input  logic                        rx_active,
   input  logic                        rx_done,
   input  logic [2:0]                  rx_error,
   input  logic [7:0]                  rx_data,
   output logic                        rx_enable,
   output logic [1:0]                  baud_rate,
   output logic [1:0]                  parity_type,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [7:0]                  m_data,
   output logic [2:0]                  m_error,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy,
   output logic                        overflow,
   output logic                        timeout,
   output logic [7:0]                  err_count
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   rx_ctrl_state_t state;
   rx_ctrl_state_t state_nxt;

   logic [1:0]       act_sync;
   logic [1:0]       done_sync;
   logic             act_prev;
   logic             done_prev;
   logic             act_rise;
   logic             done_rise;

   logic [TMR_W-1:0] timer;
   logic             tmr_tc;
   logic             tmr_load;

   logic             latch_cfg;
   logic             store_req;
   logic             set_tmo;
   logic             set_ovf;
   logic             push_ok;
   logic             err_inc;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   rx_entry_t        fifo_in;
   rx_entry_t        fifo_head;

   // Rise detectors are registered so done_rise lands two edges after first sample.
   always_ff @(posedge clock) begin
      if (reset) begin
         act_sync  <= '0;
         done_sync <= '0;
         act_prev  <= 1'b0;
         done_prev <= 1'b0;
         act_rise  <= 1'b0;
         done_rise <= 1'b0;
      end else begin
         act_sync  <= {act_sync[0], rx_active};
         done_sync <= {done_sync[0], rx_done};
         act_prev  <= act_sync[1];
         done_prev <= done_sync[1];
         act_rise  <= act_sync[1] & ~act_prev;
         done_rise <= done_sync[1] & ~done_prev;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= DISABLED;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_cfg = 1'b0;
      tmr_load  = 1'b0;
      set_tmo   = 1'b0;
      store_req = 1'b0;
      case (state)
         DISABLED: begin
            if (cfg_enable) begin
               latch_cfg = 1'b1;
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            // A done edge here means the start was missed; keep the byte anyway.
            if (done_rise) begin
               state_nxt = STORE;
            end else if (act_rise) begin
               tmr_load  = 1'b1;
               state_nxt = RECV;
            end else if (!cfg_enable) begin
               state_nxt = DISABLED;
            end
         end
         RECV: begin
            if (done_rise) begin
               state_nxt = STORE;
            end else if (tmr_tc) begin
               set_tmo   = 1'b1;
               state_nxt = ARMED;
            end
         end
         STORE: begin
            store_req = 1'b1;
            state_nxt = cfg_enable ? ARMED : DISABLED;
         end
         default: state_nxt = DISABLED;
      endcase
   end

   // Watchdog counts down from TIMEOUT_CYCLES-1; terminal count ends the frame.
   assign tmr_tc = (timer == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         timer <= '0;
      end else if (tmr_load) begin
         timer <= TMR_W'(TIMEOUT_CYCLES - 1);
      end else if (state == RECV && !tmr_tc) begin
         timer <= timer - TMR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         baud_rate   <= '0;
         parity_type <= '0;
      end else if (latch_cfg) begin
         baud_rate   <= cfg_baud;
         parity_type <= cfg_parity;
      end
   end

   assign fifo_pop = m_valid && m_ready;
   assign push_ok  = store_req && (!fifo_full || fifo_pop);
   assign set_ovf  = store_req && fifo_full && !fifo_pop;
   assign err_inc  = push_ok && any_error(rx_error);
   assign fifo_in  = '{error: rx_error, data: rx_data};

   // New events take priority over a coincident clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         timeout   <= 1'b0;
         err_count <= '0;
      end else begin
         if (set_ovf)         overflow <= 1'b1;
         else if (clr_status) overflow <= 1'b0;

         if (set_tmo)         timeout <= 1'b1;
         else if (clr_status) timeout <= 1'b0;

         if (clr_status)
            err_count <= err_inc ? 8'd1 : 8'd0;
         else if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   rx_ctrl_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (store_req),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign rx_enable = (state != DISABLED);
   assign busy      = (state == RECV) || (state == STORE);
   assign m_valid   = !fifo_empty;
   assign m_data    = fifo_empty ? 8'd0 : fifo_head.data;
   assign m_error   = fifo_empty ? 3'd0 : fifo_head.error;

endmodule
